// File: rtl/decode_stage.sv
// Instruction decode stage: field decode, register read, load-use stall with
// single-entry replay, local JMP resolution, EX redirect muxing and ID/EX register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_instr,
    input  logic [7:0]  if_pc,
    input  logic        if_valid,
    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    input  logic [7:0]  rf_rdata1,
    input  logic [7:0]  rf_rdata2,
    input  logic        ex_redirect,
    input  logic [7:0]  ex_target,
    output logic        stall,
    output logic        flush,
    output logic        pc_sel,
    output logic [7:0]  branch_target,
    output logic        id_valid,
    output logic [7:0]  id_pc,
    output logic [3:0]  id_op,
    output logic [3:0]  id_rd,
    output logic [3:0]  id_rs1,
    output logic [3:0]  id_rs2,
    output logic [7:0]  id_rs1_data,
    output logic [7:0]  id_rs2_data,
    output logic [7:0]  id_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_is_branch,
    output logic        id_halt,
    output logic        id_illegal
);
    logic        pend_valid;
    logic [15:0] pend_instr;
    logic [7:0]  pend_pc;

    logic [15:0] cur_instr;
    logic [7:0]  cur_pc;
    logic        cur_valid;
    logic [3:0]  op;
    logic [7:0]  sext_imm;

    logic [3:0]  dec_rd, dec_rs1, dec_rs2;
    logic [7:0]  dec_imm;
    logic        use_rs1, use_rs2;
    logic        dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_branch, dec_halt, dec_illegal, dec_jmp;
    logic        hazard, jmp_issue, issue;

    // The replay register always takes precedence over the fetch slot.
    assign cur_instr = pend_valid ? pend_instr : if_instr;
    assign cur_pc    = pend_valid ? pend_pc    : if_pc;
    assign cur_valid = pend_valid | if_valid;
    assign op        = cur_instr[15:12];
    assign sext_imm  = {{4{cur_instr[3]}}, cur_instr[3:0]};

    always_comb begin
        dec_rd        = 4'd0;
        dec_rs1       = 4'd0;
        dec_rs2       = 4'd0;
        dec_imm       = 8'd0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_halt      = 1'b0;
        dec_illegal   = 1'b0;
        dec_jmp       = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                dec_rd        = cur_instr[11:8];
                dec_rs1       = cur_instr[7:4];
                dec_rs2       = cur_instr[3:0];
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_reg_write = 1'b1;
            end
            4'h6: begin
                dec_rd        = cur_instr[11:8];
                dec_rs1       = cur_instr[7:4];
                use_rs1       = 1'b1;
                dec_imm       = sext_imm;
                dec_reg_write = 1'b1;
            end
            4'h7: begin
                dec_rd        = cur_instr[11:8];
                dec_imm       = cur_instr[7:0];
                dec_reg_write = 1'b1;
            end
            4'h8: begin
                dec_rd        = cur_instr[11:8];
                dec_rs1       = cur_instr[7:4];
                use_rs1       = 1'b1;
                dec_imm       = sext_imm;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            4'h9: begin
                dec_rs2       = cur_instr[11:8];
                dec_rs1       = cur_instr[7:4];
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_imm       = sext_imm;
                dec_mem_write = 1'b1;
            end
            4'hA: begin
                dec_rs1    = cur_instr[11:8];
                dec_rs2    = cur_instr[7:4];
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_imm    = cur_pc + 8'd1 + sext_imm;
                dec_branch = 1'b1;
            end
            4'hB:                dec_jmp     = 1'b1;
            4'hC, 4'hD, 4'hE:    dec_illegal = 1'b1;
            4'hF:                dec_halt    = 1'b1;
            default: ;
        endcase
    end

    assign rf_raddr1 = dec_rs1;
    assign rf_raddr2 = dec_rs2;

    assign hazard = cur_valid & id_valid & id_mem_read &
                    ((use_rs1 & (id_rd == dec_rs1)) | (use_rs2 & (id_rd == dec_rs2)));
    assign stall     = hazard & ~ex_redirect;
    assign jmp_issue = cur_valid & dec_jmp & ~ex_redirect;
    assign pc_sel    = ex_redirect | jmp_issue;
    assign flush     = pc_sel;
    assign branch_target = ex_redirect ? ex_target : cur_instr[7:0];
    assign issue     = cur_valid & ~ex_redirect & ~hazard & ~dec_jmp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid   <= 1'b0;
            pend_instr   <= 16'd0;
            pend_pc      <= 8'd0;
            id_valid     <= 1'b0;
            id_pc        <= 8'd0;
            id_op        <= 4'd0;
            id_rd        <= 4'd0;
            id_rs1       <= 4'd0;
            id_rs2       <= 4'd0;
            id_rs1_data  <= 8'd0;
            id_rs2_data  <= 8'd0;
            id_imm       <= 8'd0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_is_branch <= 1'b0;
            id_halt      <= 1'b0;
            id_illegal   <= 1'b0;
        end else begin
            if (stall) begin
                // A stalled fetch-slot instruction is parked for replay.
                if (!pend_valid) begin
                    pend_instr <= if_instr;
                    pend_pc    <= if_pc;
                end
                pend_valid <= 1'b1;
            end else begin
                pend_valid <= 1'b0;
            end
            id_valid     <= issue;
            id_pc        <= issue ? cur_pc        : 8'd0;
            id_op        <= issue ? op            : 4'd0;
            id_rd        <= issue ? dec_rd        : 4'd0;
            id_rs1       <= issue ? dec_rs1       : 4'd0;
            id_rs2       <= issue ? dec_rs2       : 4'd0;
            id_rs1_data  <= issue ? rf_rdata1     : 8'd0;
            id_rs2_data  <= issue ? rf_rdata2     : 8'd0;
            id_imm       <= issue ? dec_imm       : 8'd0;
            id_reg_write <= issue & dec_reg_write;
            id_mem_read  <= issue & dec_mem_read;
            id_mem_write <= issue & dec_mem_write;
            id_is_branch <= issue & dec_branch;
            id_halt      <= issue & dec_halt;
            id_illegal   <= issue & dec_illegal;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: drives at negedge, checks comb outputs
// shortly after, checks ID/EX just after the following posedge.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [7:0]  rf_rdata1, rf_rdata2;
  logic        ex_redirect;
  logic [7:0]  ex_target;
  logic        stall, flush, pc_sel;
  logic [7:0]  branch_target;
  logic        id_valid;
  logic [7:0]  id_pc;
  logic [3:0]  id_op, id_rd, id_rs1, id_rs2;
  logic [7:0]  id_rs1_data, id_rs2_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_halt, id_illegal;

  int total = 0;
  int bad = 0;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .stall(stall), .flush(flush), .pc_sel(pc_sel), .branch_target(branch_target),
    .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_is_branch(id_is_branch), .id_halt(id_halt), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one fetch slot at the negedge, then settle combinational outputs.
  task automatic drive(input logic [15:0] instr, input logic [7:0] pc, input logic valid);
    @(negedge clk);
    if_instr = instr;
    if_pc    = pc;
    if_valid = valid;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_instr = 16'h1123; if_pc = 8'h00; if_valid = 1'b1;
    rf_rdata1 = 8'h00; rf_rdata2 = 8'h00;
    ex_redirect = 1'b0; ex_target = 8'h00;

    // Reset with a live instruction at the input.
    tick(); tick();
    check("rst_id_valid", id_valid, 0);
    check("rst_id_op", id_op, 0);
    check("rst_id_reg_write", id_reg_write, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;

    // ADD r1 = r2 + r3
    drive(16'h1123, 8'h05, 1'b1);
    rf_rdata1 = 8'h10; rf_rdata2 = 8'h20; #1;
    check("add_raddr1", rf_raddr1, 4'h2);
    check("add_raddr2", rf_raddr2, 4'h3);
    check("add_pc_sel", pc_sel, 0);
    tick();
    check("add_valid", id_valid, 1);
    check("add_op", id_op, 4'h1);
    check("add_rd", id_rd, 4'h1);
    check("add_rs1_data", id_rs1_data, 8'h10);
    check("add_rs2_data", id_rs2_data, 8'h20);
    check("add_reg_write", id_reg_write, 1);
    check("add_pc", id_pc, 8'h05);

    // Load-use: LD r3,[r4+0] then ADD r5 = r3 + r6
    drive(16'h8340, 8'h06, 1'b1);
    check("ld_raddr1", rf_raddr1, 4'h4);
    check("ld_raddr2", rf_raddr2, 4'h0);
    tick();
    check("ld_mem_read", id_mem_read, 1);
    check("ld_rd", id_rd, 4'h3);
    check("ld_op", id_op, 4'h8);
    drive(16'h1536, 8'h07, 1'b1);
    check("lu_stall", stall, 1);
    check("lu_flush", flush, 0);
    tick();
    check("lu_bubble", id_valid, 0);
    check("lu_bubble_op", id_op, 0);
    drive(16'h0000, 8'h08, 1'b0);
    rf_rdata1 = 8'h33; rf_rdata2 = 8'h66; #1;
    check("replay_stall", stall, 0);
    check("replay_raddr1", rf_raddr1, 4'h3);
    check("replay_raddr2", rf_raddr2, 4'h6);
    tick();
    check("replay_valid", id_valid, 1);
    check("replay_op", id_op, 4'h1);
    check("replay_rd", id_rd, 4'h5);
    check("replay_pc", id_pc, 8'h07);
    check("replay_rs1_data", id_rs1_data, 8'h33);
    drive(16'h0000, 8'h09, 1'b0);
    tick();
    check("post_replay_idle", id_valid, 0);

    // JMP 0x42
    drive(16'hB042, 8'h10, 1'b1);
    check("jmp_pc_sel", pc_sel, 1);
    check("jmp_target", branch_target, 8'h42);
    check("jmp_flush", flush, 1);
    check("jmp_stall", stall, 0);
    tick();
    check("jmp_bubble", id_valid, 0);

    // EX redirect beats a local JMP
    drive(16'hB042, 8'h11, 1'b1);
    ex_redirect = 1'b1; ex_target = 8'h80; #1;
    check("redir_target", branch_target, 8'h80);
    check("redir_pc_sel", pc_sel, 1);
    check("redir_flush", flush, 1);
    tick();
    check("redir_bubble", id_valid, 0);
    ex_redirect = 1'b0;

    // BEQ r1,r2 with offset -1 at pc 0xFF: target wraps to 0xFF
    drive(16'hA12F, 8'hFF, 1'b1);
    tick();
    check("beq_imm", id_imm, 8'hFF);
    check("beq_branch", id_is_branch, 1);
    check("beq_rs1", id_rs1, 4'h1);
    check("beq_rs2", id_rs2, 4'h2);
    check("beq_reg_write", id_reg_write, 0);

    drive(16'hC000, 8'h20, 1'b1);
    tick();
    check("ill_valid", id_valid, 1);
    check("ill_flag", id_illegal, 1);
    check("ill_reg_write", id_reg_write, 0);

    drive(16'hF000, 8'h21, 1'b1);
    tick();
    check("halt_valid", id_valid, 1);
    check("halt_flag", id_halt, 1);

    // ADDI rA = r4 + (-2)
    drive(16'h6A4E, 8'h22, 1'b1);
    check("addi_raddr2", rf_raddr2, 4'h0);
    tick();
    check("addi_imm", id_imm, 8'hFE);
    check("addi_rd", id_rd, 4'hA);
    check("addi_rs2", id_rs2, 4'h0);

    // ST r5 -> [r7+2]
    drive(16'h9572, 8'h23, 1'b1);
    check("st_raddr1", rf_raddr1, 4'h7);
    check("st_raddr2", rf_raddr2, 4'h5);
    tick();
    check("st_mem_write", id_mem_write, 1);
    check("st_reg_write", id_reg_write, 0);
    check("st_imm", id_imm, 8'h02);
    check("st_rd", id_rd, 4'h0);

    // LDI rB = 0xC3
    drive(16'h7BC3, 8'h24, 1'b1);
    check("ldi_raddr1", rf_raddr1, 4'h0);
    tick();
    check("ldi_imm", id_imm, 8'hC3);
    check("ldi_rd", id_rd, 4'hB);

    // Redirect arriving on a load-use cycle discards the dependent op
    drive(16'h8340, 8'h30, 1'b1);
    tick();
    drive(16'h1536, 8'h31, 1'b1);
    ex_redirect = 1'b1; ex_target = 8'h90; #1;
    check("redir_lu_stall", stall, 0);
    check("redir_lu_target", branch_target, 8'h90);
    tick();
    ex_redirect = 1'b0;
    check("redir_lu_bubble", id_valid, 0);
    drive(16'h0000, 8'h32, 1'b0);
    tick();
    check("redir_lu_no_replay", id_valid, 0);

    // Reset while an instruction is parked: no replay afterwards
    drive(16'h8340, 8'h40, 1'b1);
    tick();
    drive(16'h1536, 8'h41, 1'b1);
    check("rst_lu_stall", stall, 1);
    tick();
    drive(16'h0000, 8'h42, 1'b0);
    reset = 1'b1; #1;
    check("rst_mid_raddr1", rf_raddr1, 4'h0);
    reset = 1'b0; #1;
    tick();
    check("rst_mid_no_replay", id_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
